// File: rtl/arith_seq_pkg.sv
// arith_seq_pkg: shared definitions for the arithmetic command sequencer.
//   - op codes and the command word layout {op, A, B}
//   - register byte offsets and STATUS / CTRL bit positions
//   - FSM state encoding
//   - fixed result words for rejected and timed-out operations
package arith_seq_pkg;

  typedef enum logic [1:0] {
    OP_MULT    = 2'd0,
    OP_DIV     = 2'd1,
    OP_SQRT    = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_e;

  typedef struct packed {
    op_e         op;
    logic [15:0] a;
    logic [15:0] b;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);
  localparam int RES_W = 32;

  localparam logic [4:0] ADDR_CMD    = 5'h00;
  localparam logic [4:0] ADDR_OPA    = 5'h04;
  localparam logic [4:0] ADDR_OPB    = 5'h08;
  localparam logic [4:0] ADDR_STATUS = 5'h0C;
  localparam logic [4:0] ADDR_RESULT = 5'h10;
  localparam logic [4:0] ADDR_CTRL   = 5'h14;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_ERR     = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_UNF     = 3;
  localparam int STAT_CMD_LSB = 8;
  localparam int STAT_RES_LSB = 16;

  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_CLEAR = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_STORE = 2'd3
  } state_e;

  localparam logic [31:0] ERR_RESULT     = 32'hFFFF_FFFF;
  localparam logic [31:0] TIMEOUT_RESULT = 32'hDEAD_DEAD;

  // Engine select for an op; the illegal op maps to no engine.
  function automatic logic [2:0] op_onehot(input op_e op);
    case (op)
      OP_MULT: return 3'b001;
      OP_DIV:  return 3'b010;
      OP_SQRT: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/arith_sequencer_if.sv
// arith_sequencer_if: CPU register bus plus the shared engine bus.
//   CPU side   : d_in, cs, addr, rd, wr (to sequencer), d_out (from sequencer)
//   Engine side: eng_a, eng_b, eng_start (from sequencer),
//                eng_done, mult_result, div_result, sqrt_result (to sequencer)
//   slave  = sequencer view, master = CPU/engine environment view.
interface arith_sequencer_if;
  import arith_seq_pkg::*;

  logic [31:0] d_in;
  logic        cs;
  logic [4:0]  addr;
  logic        rd;
  logic        wr;
  logic [31:0] d_out;

  logic [15:0] eng_a;
  logic [15:0] eng_b;
  logic [2:0]  eng_start;
  logic [2:0]  eng_done;
  logic [31:0] mult_result;
  logic [31:0] div_result;
  logic [15:0] sqrt_result;

  modport slave (
    input  d_in, cs, addr, rd, wr,
    input  eng_done, mult_result, div_result, sqrt_result,
    output d_out, eng_a, eng_b, eng_start
  );

  modport master (
    output d_in, cs, addr, rd, wr,
    output eng_done, mult_result, div_result, sqrt_result,
    input  d_out, eng_a, eng_b, eng_start
  );

endinterface

// File: rtl/arith_sequencer_fifo.sv
// seq_fifo: synchronous FIFO with first-word fall-through head.
//   clk, reset (sync, active-high), clear (sync flush)
//   push/wdata, pop -> rdata is the current head
//   count, full, empty
// A push to a full FIFO is accepted when a pop happens on the same edge;
// pops on an empty FIFO are ignored. clear wins over push/pop.
module seq_fifo
  import arith_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("seq_fifo DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/arith_sequencer.sv
// arith_sequencer: memory-mapped command scheduler for the mult/div/sqrt
// engines. The CPU queues {op, A, B}; commands are issued one at a time
// through a start/done handshake and results are collected in order.
//   clk, reset (sync, active-high)
//   bus (arith_sequencer_if.slave): CPU register port and engine bus
// Optional build macro ARITH_SEQ_TIMEOUT_EN adds an engine watchdog of
// TIMEOUT_CYCLES cycles in WAIT; without it WAIT waits indefinitely.
//
// state | meaning
// IDLE  | waiting for a queued command and room in the result FIFO
// ISSUE | head latched; start pulse to engine, or reject illegal op / div by 0
// WAIT  | operands held, waiting for the selected engine's done
// STORE | push result (unless flushed), pop command
module arith_sequencer
  import arith_seq_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  arith_sequencer_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("arith_sequencer TIMEOUT_CYCLES must be at least 1");
  end

  logic          wr_en, rd_en;
  logic [15:0]   opa_q, opb_q;
  logic          flush, clr_flags;
  logic          err_q, ovf_q, unf_q;
  logic          err_set, ovf_set, unf_set;
  logic          busy;
  logic [31:0]   status_word;

  logic             cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic [CMD_W-1:0] cmd_wdata, cmd_rdata;
  logic [CW-1:0]    cmd_count;
  cmd_t             cmd_head;

  logic             res_push, res_pop, res_full, res_empty;
  logic [RES_W-1:0] res_rdata;
  logic [CW-1:0]    res_count;

  state_e        state_q, state_d;
  op_e           cur_op;
  logic [15:0]   cur_a, cur_b;
  logic [31:0]   result_q;
  logic [31:0]   eng_result;
  logic          discard_q;
  logic          go, illegal, done_hit, tmo_hit;
  logic [2:0]    eng_start_c;

  logic          unused_d_in_hi;
  assign unused_d_in_hi = ^bus.d_in[31:16];

  // CPU register port
  assign wr_en     = bus.cs & bus.wr;
  assign rd_en     = bus.cs & bus.rd;
  assign cmd_push  = wr_en && (bus.addr == ADDR_CMD);
  assign cmd_wdata = {bus.d_in[1:0], opa_q, opb_q};
  assign res_pop   = rd_en && (bus.addr == ADDR_RESULT);
  assign flush     = wr_en && (bus.addr == ADDR_CTRL) && bus.d_in[CTRL_FLUSH];
  assign clr_flags = wr_en && (bus.addr == ADDR_CTRL) && bus.d_in[CTRL_CLEAR];

  // A full-FIFO push only survives if the FSM pops on the same edge.
  assign ovf_set = cmd_push & cmd_full & ~cmd_pop & ~flush;
  assign unf_set = res_pop & res_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      opa_q <= '0;
      opb_q <= '0;
    end else if (wr_en) begin
      if (bus.addr == ADDR_OPA) opa_q <= bus.d_in[15:0];
      if (bus.addr == ADDR_OPB) opb_q <= bus.d_in[15:0];
    end
  end

  // Sticky flags: a new event in the same cycle as a clear is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (err_set)        err_q <= 1'b1;
      else if (clr_flags) err_q <= 1'b0;
      if (ovf_set)        ovf_q <= 1'b1;
      else if (clr_flags) ovf_q <= 1'b0;
      if (unf_set)        unf_q <= 1'b1;
      else if (clr_flags) unf_q <= 1'b0;
    end
  end

  assign busy = (state_q != ST_IDLE) || !cmd_empty;

  always_comb begin
    status_word                              = '0;
    status_word[STAT_RES_LSB +: 8]           = 8'(res_count);
    status_word[STAT_CMD_LSB +: 8]           = 8'(cmd_count);
    status_word[STAT_UNF]                    = unf_q;
    status_word[STAT_OVF]                    = ovf_q;
    status_word[STAT_ERR]                    = err_q;
    status_word[STAT_BUSY]                   = busy;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.d_out <= '0;
    end else if (rd_en) begin
      case (bus.addr)
        ADDR_STATUS: bus.d_out <= status_word;
        ADDR_RESULT: bus.d_out <= res_empty ? '0 : res_rdata;
        default:     bus.d_out <= '0;
      endcase
    end
  end

  seq_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (cmd_push),
    .pop   (cmd_pop),
    .wdata (cmd_wdata),
    .rdata (cmd_rdata),
    .count (cmd_count),
    .full  (cmd_full),
    .empty (cmd_empty)
  );

  seq_fifo #(.WIDTH(RES_W), .DEPTH(DEPTH)) u_res_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (res_push),
    .pop   (res_pop),
    .wdata (result_q),
    .rdata (res_rdata),
    .count (res_count),
    .full  (res_full),
    .empty (res_empty)
  );

  assign cmd_head = cmd_t'(cmd_rdata);

  // A flush on the same edge would leave a stale head latched, so hold off.
  assign go       = (state_q == ST_IDLE) && !cmd_empty && !res_full && !flush;
  assign illegal  = (cur_op == OP_ILLEGAL) || ((cur_op == OP_DIV) && (cur_b == '0));
  assign done_hit = (state_q == ST_WAIT) && |(bus.eng_done & op_onehot(cur_op));

`ifdef ARITH_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Loaded while in ISSUE so WAIT cycle N sees TIMEOUT_CYCLES-N; zero marks
  // the last allowed cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state_q == ST_ISSUE) begin
      tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
    end else if ((state_q == ST_WAIT) && (tmo_cnt != '0)) begin
      tmo_cnt <= tmo_cnt - 1'b1;
    end
  end

  assign tmo_hit = (state_q == ST_WAIT) && (tmo_cnt == '0) && !done_hit;
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (go) state_d = ST_ISSUE;
      ST_ISSUE: state_d = illegal ? ST_STORE : ST_WAIT;
      ST_WAIT:  if (done_hit || tmo_hit) state_d = ST_STORE;
      ST_STORE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    eng_start_c = '0;
    cmd_pop     = 1'b0;
    res_push    = 1'b0;
    err_set     = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        if (illegal) err_set     = 1'b1;
        else         eng_start_c = op_onehot(cur_op);
      end
      ST_WAIT:  err_set = tmo_hit;
      ST_STORE: begin
        cmd_pop  = !discard_q;
        res_push = !discard_q;
      end
      default: ;
    endcase
  end

  assign bus.eng_start = eng_start_c;
  assign bus.eng_a     = cur_a;
  assign bus.eng_b     = cur_b;

  always_comb begin
    case (cur_op)
      OP_MULT: eng_result = bus.mult_result;
      OP_DIV:  eng_result = bus.div_result;
      OP_SQRT: eng_result = {16'h0000, bus.sqrt_result};
      default: eng_result = '0;
    endcase
  end

  // A flush while an op is in flight marks it for discard: the engine is
  // still allowed to finish, but STORE neither pushes nor pops.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_op    <= OP_MULT;
      cur_a     <= '0;
      cur_b     <= '0;
      result_q  <= '0;
      discard_q <= 1'b0;
    end else begin
      if (go) begin
        cur_op    <= cmd_head.op;
        cur_a     <= cmd_head.a;
        cur_b     <= cmd_head.b;
        discard_q <= 1'b0;
      end else if (flush && ((state_q == ST_ISSUE) || (state_q == ST_WAIT))) begin
        discard_q <= 1'b1;
      end
      if ((state_q == ST_ISSUE) && illegal) result_q <= ERR_RESULT;
      else if (done_hit)                    result_q <= eng_result;
      else if (tmo_hit)                     result_q <= TIMEOUT_RESULT;
    end
  end

endmodule

// File: tb/tb_arith_sequencer.sv
module tb_arith_sequencer;
  import arith_seq_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arith_sequencer_if bus();

  arith_sequencer #(.DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Engine model: one shared responder, done after lat cycles unless stalled.
  logic [15:0] ea = '0, eb = '0;
  logic [2:0]  eop = '0;
  logic [2:0]  done_drv = '0;
  bit          pend = 0;
  bit          stall = 0;
  int          cnt = 0;
  int          lat = 5;
  int          n_mult = 0, n_div = 0, n_sqrt = 0, bad_start = 0;

  function automatic logic [15:0] isqrt(input logic [15:0] v);
    int r = 0;
    for (int i = 0; i < 256; i++) if (i * i <= int'(v)) r = i;
    return 16'(r);
  endfunction

  assign bus.eng_done    = done_drv;
  assign bus.mult_result = 32'(ea) * 32'(eb);
  assign bus.div_result  = (eb == 0) ? 32'h0 : {ea % eb, ea / eb};
  assign bus.sqrt_result = isqrt(ea);

  always @(negedge clk) begin
    done_drv = 3'b000;
    if (reset) begin
      pend = 0;
    end else begin
      if (pend && !stall) begin
        if (cnt <= 1) begin
          pend = 0;
          done_drv = eop;
        end else cnt = cnt - 1;
      end
      if (bus.eng_start != 3'b000) begin
        if ($countones(bus.eng_start) != 1) bad_start++;
        if (bus.eng_start[0]) n_mult++;
        if (bus.eng_start[1]) n_div++;
        if (bus.eng_start[2]) n_sqrt++;
        pend = 1;
        cnt  = lat;
        ea   = bus.eng_a;
        eb   = bus.eng_b;
        eop  = bus.eng_start;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.d_in = d;
    @(negedge clk);
    bus.cs = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [4:0] a, output logic [31:0] d);
    bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = a;
    @(negedge clk);
    bus.cs = 1'b0; bus.rd = 1'b0;
    d = bus.d_out;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      rd_reg(ADDR_STATUS, s);
      if (s[STAT_BUSY] == 1'b0) begin
        ok = 1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    bus.cs = 0; bus.rd = 0; bus.wr = 0; bus.addr = '0; bus.d_in = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_d_out", bus.d_out, 32'h0);
    check("rst_eng_start", 32'(bus.eng_start), 32'h0);
    check("rst_eng_a", 32'(bus.eng_a), 32'h0);
    check("rst_eng_b", 32'(bus.eng_b), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    rd_reg(ADDR_STATUS, d);
    check("rst_status", d, 32'h0);

    // 1: single mult 300*200
    wr_reg(ADDR_OPA, 32'd300);
    wr_reg(ADDR_OPB, 32'd200);
    wr_reg(ADDR_CMD, 32'd0);
    wait_idle("t1_idle");
    rd_reg(ADDR_STATUS, d);
    check("t1_status", d, 32'h0001_0000);
    rd_reg(ADDR_RESULT, d);
    check("t1_result", d, 32'd60000);
    check("t1_nmult", 32'(n_mult), 32'd1);

    // 2: div 100/7, sqrt 144, mult 3*4 back to back
    wr_reg(ADDR_OPA, 32'd100);
    wr_reg(ADDR_OPB, 32'd7);
    wr_reg(ADDR_CMD, 32'd1);
    wr_reg(ADDR_OPA, 32'd144);
    wr_reg(ADDR_CMD, 32'd2);
    wr_reg(ADDR_OPA, 32'd3);
    wr_reg(ADDR_OPB, 32'd4);
    wr_reg(ADDR_CMD, 32'd0);
    wait_idle("t2_idle");
    rd_reg(ADDR_STATUS, d);
    check("t2_status", d, 32'h0003_0000);
    rd_reg(ADDR_RESULT, d);
    check("t2_div", d, 32'h0002_000E);
    rd_reg(ADDR_RESULT, d);
    check("t2_sqrt", d, 32'd12);
    rd_reg(ADDR_RESULT, d);
    check("t2_mult", d, 32'd12);
    check("t2_starts", {8'(n_mult), 8'(n_div), 8'(n_sqrt), 8'(bad_start)}, 32'h0201_0100);

    // 3: div by zero and illegal op
    wr_reg(ADDR_OPA, 32'd5);
    wr_reg(ADDR_OPB, 32'd0);
    wr_reg(ADDR_CMD, 32'd1);
    wr_reg(ADDR_CMD, 32'd3);
    wait_idle("t3_idle");
    rd_reg(ADDR_STATUS, d);
    check("t3_status", d, 32'h0002_0002);
    rd_reg(ADDR_RESULT, d);
    check("t3_res0", d, 32'hFFFF_FFFF);
    rd_reg(ADDR_RESULT, d);
    check("t3_res1", d, 32'hFFFF_FFFF);
    check("t3_nostart", 32'(n_mult + n_div + n_sqrt), 32'd4);
    wr_reg(ADDR_CTRL, 32'h2);
    rd_reg(ADDR_STATUS, d);
    check("t3_err_clr", d, 32'h0);

    // 4: overflow with a stalled mult, then underflow
    stall = 1;
    wr_reg(ADDR_OPA, 32'd1);
    wr_reg(ADDR_OPB, 32'd1);
    repeat (5) wr_reg(ADDR_CMD, 32'd0);
    rd_reg(ADDR_STATUS, d);
    check("t4_ovf_status", d, 32'h0000_0405);
    check("t4_one_issue", 32'(n_mult), 32'd3);
    rd_reg(ADDR_RESULT, d);
    check("t4_unf_data", d, 32'h0);
    rd_reg(ADDR_STATUS, d);
    check("t4_unf_status", d, 32'h0000_040D);
    rd_reg(32'h18, d);
    check("t4_other_addr", d, 32'h0);

    // 5a: flush during WAIT, then late done is discarded
    wr_reg(ADDR_CTRL, 32'h3);
    rd_reg(ADDR_STATUS, d);
    check("t5_flush_status", d, 32'h0000_0001);
    stall = 0;
    wait_idle("t5_idle");
    rd_reg(ADDR_STATUS, d);
    check("t5_after_done", d, 32'h0);

    // 5b: reset mid-WAIT
    stall = 1;
    wr_reg(ADDR_OPA, 32'd9);
    wr_reg(ADDR_OPB, 32'd8);
    wr_reg(ADDR_CMD, 32'd0);
    repeat (4) @(negedge clk);
    check("t5_hold_a", 32'(bus.eng_a), 32'd9);
    rd_reg(ADDR_STATUS, d);
    check("t5_wait_status", d, 32'h0000_0101);
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_outs", {bus.d_out[15:0], bus.eng_a[7:0], bus.eng_b[4:0], bus.eng_start}, 32'h0);
    reset = 1'b0;
    stall = 0;
    @(negedge clk);
    rd_reg(ADDR_STATUS, d);
    check("t5_rst_status", d, 32'h0);

`ifdef ARITH_SEQ_TIMEOUT_EN
    // 6: engine never answers, watchdog fires
    stall = 1;
    wr_reg(ADDR_OPA, 32'd2);
    wr_reg(ADDR_OPB, 32'd3);
    wr_reg(ADDR_CMD, 32'd0);
    wait_idle("t6_idle");
    rd_reg(ADDR_RESULT, d);
    check("t6_result", d, 32'hDEAD_DEAD);
    stall = 0;
    repeat (10) @(negedge clk);
    rd_reg(ADDR_STATUS, d);
    check("t6_status", d, 32'h0000_0002);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arith_sequencer.md
Name: arith_sequencer

Overview:
Memory-mapped command scheduler for the SoC's multiplier, divider and square-root engines, decoded at chip-select 0x0047xxxx.
- The CPU queues {op, A, B} commands.
- The block issues them one at a time to the selected engine through a start/done handshake.
- Results are collected in order into a result FIFO, so firmware no longer busy-polls each peripheral.

Parameters:
DEPTH, 4, entries in the command FIFO and in the result FIFO; power of 2, minimum 2.
TIMEOUT_CYCLES, 1024, engine watchdog limit in cycles; used only when ARITH_SEQ_TIMEOUT_EN is defined.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
d_in  in  32  CPU write data.
cs  in  1  chip select.
addr  in  5  byte offset within the block.
rd  in  1  read strobe.
wr  in  1  write strobe.
d_out  out  32  read data, registered.
eng_a  out  16  operand A to all engines.
eng_b  out  16  operand B to all engines.
eng_start  out  3  one-hot start pulse: bit0 mult, bit1 div, bit2 sqrt.
eng_done  in  3  one-cycle done pulse from each engine.
mult_result  in  32  product.
div_result  in  32  {remainder[15:0], quotient[15:0]}.
sqrt_result  in  16  root.

Behaviour:
Reset:
- All outputs are 0.
- Both FIFOs are empty, sticky flags are clear, FSM is in IDLE.
- Reset asserted mid-operation aborts at once; eng_start is 0 in the following cycle.

Register map (accesses require cs):
- 0x04 write: OPA ← d_in[15:0].
- 0x08 write: OPB ← d_in[15:0].
- 0x00 write: push {d_in[1:0], OPA, OPB} into the command FIFO.
  - If the command FIFO is full, the push is dropped and sticky OVF is set.
- 0x0C read: STATUS = {res_count[23:16], cmd_count[15:8], 4'b0, UNF, OVF, ERR, busy}.
- 0x10 read: pop the result FIFO.
  - If the result FIFO is empty, return 0 and set sticky UNF.
- 0x14 write:
  - bit0 = flush both FIFOs.
  - bit1 = clear the OVF, UNF and ERR flags.
- Any other offset reads 0.

Read timing:
- d_out is updated on the clock edge where cs & rd is high.
- The pop takes effect on the same edge; read latency is 1 cycle.

Op codes: 0 = mult, 1 = div, 2 = sqrt, 3 = illegal.

FSM states IDLE, ISSUE, WAIT, STORE:
- IDLE → ISSUE when the command FIFO is non-empty and the result FIFO is not full. Head fields are latched.
- ISSUE:
  - Drive eng_a and eng_b, and pulse eng_start[op] for exactly 1 cycle; then go to WAIT.
  - Short-circuit, no start pulse, go straight to STORE with result 0xFFFF_FFFF and ERR set, when:
    - op = 3, or
    - op = 1 with B = 0.
- WAIT:
  - eng_a and eng_b are held stable.
  - Waits for eng_done[op]; done bits of other engines are ignored.
  - Captures the result, zero-extending sqrt to 32 bits, then goes to STORE.
- STORE: push the result, pop the command, return to IDLE.
  - Minimum command-to-result time is 3 cycles plus engine latency.
- busy = (state ≠ IDLE) or command FIFO non-empty.

Simultaneous events and boundaries:
- A CPU push and an FSM pop in the same cycle: both take effect and the count is unchanged.
- The same applies to the result FIFO.
- FIFO pointers wrap modulo DEPTH.
- Flush during WAIT: the FSM still waits for done, then discards that result (nothing is pushed) and returns to IDLE.

Optional Feature:
ARITH_SEQ_TIMEOUT_EN:
- Defined:
  - WAIT counts cycles.
  - At TIMEOUT_CYCLES without done, the block abandons the op: pushes 0xDEAD_DEAD, sets ERR, goes to STORE.
  - A late done for that op is ignored.
- Undefined: WAIT waits indefinitely and no counter is synthesised.

Decomposition:
- Package arith_seq_pkg holds:
  - op codes;
  - register offsets;
  - FSM state encoding;
  - the constants ERR_RESULT = 0xFFFF_FFFF and TIMEOUT_RESULT = 0xDEAD_DEAD;
  - STATUS bit positions.
- One sub-module, seq_fifo (parameters WIDTH and DEPTH, synchronous clear, count output).
  - Instantiated twice: command FIFO at 34 bits, result FIFO at 32 bits.

Test Plan:
1. Mult: OPA = 300, OPB = 200, CMD = 0; mult done after 5 cycles → RESULT = 60000, STATUS.busy returns to 0.
2. Queue div 100/7, sqrt 144, mult 3×4 back-to-back → results in order: 0x0002_000E, 12, 12; eng_start pulses exactly once each.
3. Div 5/0 and op 3 → two results of 0xFFFF_FFFF, ERR = 1, eng_start never asserted; CTRL bit1 clears ERR.
4. Overflow and underflow:
   - Push DEPTH + 1 commands while the mult engine is stalled (done held low) → OVF = 1, cmd_count = DEPTH.
   - Read RESULT on an empty FIFO → 0, UNF = 1.
5. Flush and reset:
   - Flush during WAIT, then done → res_count = 0, FSM in IDLE.
   - Assert reset mid-WAIT → all outputs 0 on the next cycle.
6. With ARITH_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES = 16, done never arrives → RESULT = 0xDEAD_DEAD at cycle 16 of WAIT, ERR = 1.
